// File: rtl/bp_fe_controller_mt_if.sv
// FE controller bus: BE command channel, attaboy forwarding, I$ fetch port,
// IF2 exception return path, poison/ITLB strobes and per-thread state.
// master = environment (BE / predictor / I$), slave = the controller.
interface bp_fe_controller_mt_if #(
  parameter int threads_p     = 2,
  parameter int vaddr_width_p = 39
);
  localparam int tid_w_lp = (threads_p > 1) ? $clog2(threads_p) : 1;

  logic                     init_done_i;
  logic                     fe_cmd_v_i;
  logic [tid_w_lp-1:0]      fe_cmd_tid_i;
  logic [3:0]               fe_cmd_opcode_i;
  logic [vaddr_width_p-1:0] fe_cmd_npc_i;
  logic                     fe_cmd_yumi_o;
  logic                     attaboy_v_o;
  logic                     attaboy_yumi_i;
  logic                     icache_v_o;
  logic [tid_w_lp-1:0]      icache_tid_o;
  logic [vaddr_width_p-1:0] icache_vaddr_o;
  logic                     icache_fence_o;
  logic                     icache_yumi_i;
  logic                     if2_exception_v_i;
  logic [tid_w_lp-1:0]      if2_exception_tid_i;
  logic [threads_p-1:0]     poison_o;
  logic                     itlb_fill_v_o;
  logic                     itlb_fence_v_o;
  logic [2*threads_p-1:0]   state_o;

  modport slave (
    input  init_done_i, fe_cmd_v_i, fe_cmd_tid_i, fe_cmd_opcode_i, fe_cmd_npc_i,
           attaboy_yumi_i, icache_yumi_i, if2_exception_v_i, if2_exception_tid_i,
    output fe_cmd_yumi_o, attaboy_v_o, icache_v_o, icache_tid_o, icache_vaddr_o,
           icache_fence_o, poison_o, itlb_fill_v_o, itlb_fence_v_o, state_o
  );

  modport master (
    output init_done_i, fe_cmd_v_i, fe_cmd_tid_i, fe_cmd_opcode_i, fe_cmd_npc_i,
           attaboy_yumi_i, icache_yumi_i, if2_exception_v_i, if2_exception_tid_i,
    input  fe_cmd_yumi_o, attaboy_v_o, icache_v_o, icache_tid_o, icache_vaddr_o,
           icache_fence_o, poison_o, itlb_fill_v_o, itlb_fence_v_o, state_o
  );
endinterface

// File: rtl/bp_fe_controller_mt.sv
// Multi-threaded FE fetch controller: per-thread FSM + PC, round-robin I$ port.
// Latency: command/exception effects and strobes are same-cycle; state/PC update next edge.
// Backpressure: attaboy waits for attaboy_yumi_i; state_reset stalls until init_done_i.
module bp_fe_controller_mt #(
  parameter int threads_p            = 2,
  parameter int vaddr_width_p        = 39,
  parameter int fetch_bytes_p        = 4,
  parameter int compressed_support_p = 1
) (
  input logic                  clk_i,
  input logic                  reset_i,
  bp_fe_controller_mt_if.slave bus
);
  localparam int tid_w_lp = (threads_p > 1) ? $clog2(threads_p) : 1;

  typedef enum logic [1:0] {e_reset = 2'd0, e_wait = 2'd1, e_run = 2'd2, e_resume = 2'd3} state_e;

  state_e                   state_q [threads_p];
  state_e                   state_d [threads_p];
  logic [vaddr_width_p-1:0] pc_q    [threads_p];
  logic [vaddr_width_p-1:0] pc_d    [threads_p];
  logic [tid_w_lp-1:0]      rr_q, rr_d;

  logic [3:0]               opc;
  logic                     atta_op;
  logic                     is_atta;
  logic [vaddr_width_p-1:0] npc_eff;
  state_e                   cmd_state;
  logic [threads_p-1:0]     cmd_hit, exc_hit, cmd_act, cmd_boot, elig;
  logic                     tgt_reset, tgt_active;
  logic                     gnt_v;
  int                       gnt_idx;
  int                       idx;

  // Command decode, per-thread next state/PC, round-robin grant and outputs
  always_comb begin
    opc     = bus.fe_cmd_opcode_i;
    atta_op = (opc == 4'd9);
    is_atta = bus.fe_cmd_v_i & atta_op;
    // Resume variants restart on the half-word before the faulting parcel
    npc_eff = ((compressed_support_p != 0) && ((opc == 4'd3) || (opc == 4'd5)))
              ? bus.fe_cmd_npc_i - vaddr_width_p'(2) : bus.fe_cmd_npc_i;
    case (opc)
      4'd6, 4'd8:       cmd_state = e_wait;
      4'd1, 4'd2, 4'd3: cmd_state = e_run;
      default:          cmd_state = e_resume;
    endcase

    tgt_reset  = 1'b0;
    tgt_active = 1'b0;
    cmd_hit    = '0;
    exc_hit    = '0;
    cmd_act    = '0;
    cmd_boot   = '0;
    elig       = '0;
    for (int t = 0; t < threads_p; t++) begin
      state_d[t] = state_q[t];
      pc_d[t]    = pc_q[t];
      cmd_hit[t] = bus.fe_cmd_v_i & ~atta_op &
                   ((threads_p == 1) || (bus.fe_cmd_tid_i == tid_w_lp'(t)));
      exc_hit[t] = bus.if2_exception_v_i &
                   ((threads_p == 1) || (bus.if2_exception_tid_i == tid_w_lp'(t)));
      // A thread in RESET only honours state_reset, and only once init is done
      cmd_boot[t] = cmd_hit[t] & (state_q[t] == e_reset) & (opc == 4'd0) & bus.init_done_i;
      cmd_act[t]  = cmd_hit[t] & (state_q[t] != e_reset) & (opc <= 4'd8);
      tgt_reset   = tgt_reset | (cmd_hit[t] & (state_q[t] == e_reset));
      tgt_active  = tgt_active | cmd_act[t];
      // A thread touched by a command or exception this cycle may not fetch
      elig[t] = ((state_q[t] == e_run) || (state_q[t] == e_resume)) & ~cmd_hit[t] & ~exc_hit[t];
      if (cmd_boot[t]) begin
        state_d[t] = e_resume;
        pc_d[t]    = bus.fe_cmd_npc_i;
      end else if (cmd_act[t]) begin
        state_d[t] = cmd_state;
        pc_d[t]    = npc_eff;
      end else if (exc_hit[t]) begin
        state_d[t] = e_wait;
      end
    end

    // Search starts one past the last granted thread
    gnt_v   = 1'b0;
    gnt_idx = 0;
    idx     = 0;
    for (int i = 1; i <= threads_p; i++) begin
      idx = (int'(rr_q) + i) % threads_p;
      if (!gnt_v && elig[idx]) begin
        gnt_v   = 1'b1;
        gnt_idx = idx;
      end
    end

    rr_d = rr_q;
    for (int t = 0; t < threads_p; t++) begin
      if (bus.icache_yumi_i && gnt_v && (gnt_idx == t)) begin
        pc_d[t] = pc_q[t] + vaddr_width_p'(fetch_bytes_p);
        if (state_q[t] == e_resume) state_d[t] = e_run;
        rr_d = tid_w_lp'(t);
      end
    end

    bus.attaboy_v_o    = ~reset_i & is_atta;
    bus.fe_cmd_yumi_o  = ~reset_i & (is_atta ? bus.attaboy_yumi_i
                         : (bus.fe_cmd_v_i & ~(tgt_reset & (opc == 4'd0) & ~bus.init_done_i)));
    bus.itlb_fill_v_o  = ~reset_i & tgt_active & ((opc == 4'd4) || (opc == 4'd5));
    bus.itlb_fence_v_o = ~reset_i & tgt_active & (opc == 4'd7);
    bus.icache_fence_o = ~reset_i & tgt_active & (opc == 4'd6);
    bus.poison_o       = reset_i ? '0 : (cmd_act | exc_hit);
    bus.icache_v_o     = ~reset_i & gnt_v;
    bus.icache_tid_o   = tid_w_lp'(gnt_idx);
    bus.icache_vaddr_o = pc_q[gnt_idx];
    bus.state_o        = '0;
    for (int t = 0; t < threads_p; t++) bus.state_o[2*t +: 2] = state_q[t];
  end

  // Per-thread state, PCs and round-robin pointer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int t = 0; t < threads_p; t++) begin
        state_q[t] <= e_reset;
        pc_q[t]    <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int t = 0; t < threads_p; t++) begin
        state_q[t] <= state_d[t];
        pc_q[t]    <= pc_d[t];
      end
      rr_q <= rr_d;
    end
  end
endmodule

// File: tb/tb_bp_fe_controller_mt.sv
// Bench for bp_fe_controller_mt (2 threads, 39-bit VA, compressed on).
// A thread-level model is compared every falling edge; directed pins fix key values.
module tb_bp_fe_controller_mt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_fe_controller_mt_if #(.threads_p(2), .vaddr_width_p(39)) bus ();

  bp_fe_controller_mt #(
    .threads_p(2), .vaddr_width_p(39), .fetch_bytes_p(4), .compressed_support_p(1)
  ) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Thread model: state 0=RESET 1=WAIT 2=RUN 3=RESUME
  int          m_st [2];
  logic [38:0] m_pc [2];
  int          m_rr;
  int          c_t, c_o, x_t, g;
  bit          c_v, x_v, e_atta, e_yumi, act;
  logic [1:0]  e_poison, el;

  function automatic int target_state(input int o);
    if (o == 6 || o == 8) return 1;
    if (o >= 1 && o <= 3) return 2;
    return 3;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_yumi",    64'(bus.fe_cmd_yumi_o), 64'd0);
      chk("rst_atta",    64'(bus.attaboy_v_o),   64'd0);
      chk("rst_icv",     64'(bus.icache_v_o),    64'd0);
      chk("rst_poison",  64'(bus.poison_o),      64'd0);
      chk("rst_state",   64'(bus.state_o),       64'd0);
      chk("rst_strobes", 64'({bus.itlb_fill_v_o, bus.itlb_fence_v_o, bus.icache_fence_o}), 64'd0);
      m_st[0] = 0; m_st[1] = 0; m_pc[0] = '0; m_pc[1] = '0; m_rr = 0;
    end else begin
      c_v = bus.fe_cmd_v_i;  c_t = int'(bus.fe_cmd_tid_i);  c_o = int'(bus.fe_cmd_opcode_i);
      x_v = bus.if2_exception_v_i;  x_t = int'(bus.if2_exception_tid_i);
      e_atta = c_v && (c_o == 9);
      if (e_atta)   e_yumi = bus.attaboy_yumi_i;
      else if (c_v) e_yumi = !(m_st[c_t] == 0 && c_o == 0 && !bus.init_done_i);
      else          e_yumi = 1'b0;
      act = c_v && c_o <= 8 && m_st[c_t] != 0;
      e_poison = 2'b00;
      el = 2'b00;
      for (int t = 0; t < 2; t++) begin
        if ((act && c_t == t) || (x_v && x_t == t)) e_poison[t] = 1'b1;
        el[t] = (m_st[t] >= 2) && !(c_v && c_o != 9 && c_t == t) && !(x_v && x_t == t);
      end
      g = -1;
      for (int k = 1; k <= 2; k++) if (g < 0 && el[(m_rr + k) % 2]) g = (m_rr + k) % 2;

      chk("yumi",       64'(bus.fe_cmd_yumi_o),  64'(e_yumi));
      chk("attaboy_v",  64'(bus.attaboy_v_o),    64'(e_atta));
      chk("poison",     64'(bus.poison_o),       64'(e_poison));
      chk("itlb_fill",  64'(bus.itlb_fill_v_o),  64'(act && (c_o == 4 || c_o == 5)));
      chk("itlb_fence", 64'(bus.itlb_fence_v_o), 64'(act && c_o == 7));
      chk("ic_fence",   64'(bus.icache_fence_o), 64'(act && c_o == 6));
      chk("state",      64'(bus.state_o),        64'(m_st[1] * 4 + m_st[0]));
      chk("icache_v",   64'(bus.icache_v_o),     64'(g >= 0));
      if (g >= 0) begin
        chk("icache_tid",   64'(bus.icache_tid_o),   64'(g));
        chk("icache_vaddr", 64'(bus.icache_vaddr_o), 64'(m_pc[g]));
      end

      if (c_v && c_o != 9) begin
        if (m_st[c_t] == 0) begin
          if (c_o == 0 && bus.init_done_i) begin
            m_st[c_t] = 3;  m_pc[c_t] = bus.fe_cmd_npc_i;
          end
        end else if (c_o <= 8) begin
          m_st[c_t] = target_state(c_o);
          m_pc[c_t] = (c_o == 3 || c_o == 5) ? bus.fe_cmd_npc_i - 39'd2 : bus.fe_cmd_npc_i;
        end else if (x_v && x_t == c_t) begin
          m_st[c_t] = 1;
        end
      end
      if (x_v && !(act && c_t == x_t) &&
          !(c_v && c_o == 0 && c_t == x_t && m_st[x_t] == 3 && bus.init_done_i &&
            m_pc[x_t] == bus.fe_cmd_npc_i && e_poison[x_t] == 1'b0))
        if (!(c_v && c_o != 9 && c_t == x_t)) m_st[x_t] = 1;
      if (g >= 0 && bus.icache_yumi_i) begin
        m_pc[g] = m_pc[g] + 39'd4;
        if (m_st[g] == 3) m_st[g] = 2;
        m_rr = g;
      end
    end
  end

  task automatic drv(input int v, input int tid, input int opc, input longint npc,
                     input int icy, input int xv, input int xt, input int ay);
    bus.fe_cmd_v_i          = 1'(v);
    bus.fe_cmd_tid_i        = 1'(tid);
    bus.fe_cmd_opcode_i     = 4'(opc);
    bus.fe_cmd_npc_i        = 39'(npc);
    bus.icache_yumi_i       = 1'(icy);
    bus.if2_exception_v_i   = 1'(xv);
    bus.if2_exception_tid_i = 1'(xt);
    bus.attaboy_yumi_i      = 1'(ay);
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [38:0] t2_va [4];
  int          t2_id [4];

  initial begin
    bus.init_done_i = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pin_rst_state", 64'(bus.state_o), 64'd0);
    rst = 1'b0;

    // Boot thread 0: stall until init done
    drv(1, 0, 0, 'h8000_0000, 0, 0, 0, 0);
    chk("pin_t1_stall0", 64'(bus.fe_cmd_yumi_o), 64'd0);
    tick();
    drv(1, 0, 0, 'h8000_0000, 0, 0, 0, 0);
    chk("pin_t1_stall1", 64'(bus.fe_cmd_yumi_o), 64'd0);
    tick();
    bus.init_done_i = 1'b1;
    drv(1, 0, 0, 'h8000_0000, 0, 0, 0, 0);
    chk("pin_t1_yumi", 64'(bus.fe_cmd_yumi_o), 64'd1);
    tick();
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    chk("pin_t1_resume", 64'(bus.state_o[1:0]), 64'd3);
    chk("pin_t1_icv",    64'(bus.icache_v_o),   64'd1);
    chk("pin_t1_tid",    64'(bus.icache_tid_o), 64'd0);
    chk("pin_t1_va0",    64'(bus.icache_vaddr_o), 64'h8000_0000);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pin_t1_run", 64'(bus.state_o[1:0]), 64'd2);
    chk("pin_t1_va1", 64'(bus.icache_vaddr_o), 64'h8000_0004);
    tick();

    // Both threads running at 0x100 / 0x200, then alternate grants
    drv(1, 1, 0, 'h200, 0, 0, 0, 0);
    chk("pin_t2_boot1", 64'(bus.fe_cmd_yumi_o), 64'd1);
    tick();
    drv(1, 1, 1, 'h200, 0, 0, 0, 0);  tick();
    drv(1, 0, 1, 'h100, 0, 0, 0, 0);  tick();
    t2_id = '{1, 0, 1, 0};
    t2_va = '{39'h200, 39'h100, 39'h204, 39'h104};
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 0, 1, 0, 0, 0);
      chk("pin_t2_tid", 64'(bus.icache_tid_o),   64'(t2_id[i]));
      chk("pin_t2_va",  64'(bus.icache_vaddr_o), 64'(t2_va[i]));
      tick();
    end

    // Redirect thread 1 while thread 0 takes the port
    drv(1, 1, 1, 'h400, 1, 0, 0, 0);
    chk("pin_t3_yumi",   64'(bus.fe_cmd_yumi_o),  64'd1);
    chk("pin_t3_poison", 64'(bus.poison_o),       64'd2);
    chk("pin_t3_tid",    64'(bus.icache_tid_o),   64'd0);
    chk("pin_t3_va",     64'(bus.icache_vaddr_o), 64'h108);
    tick();
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    chk("pin_t3_tid1", 64'(bus.icache_tid_o),   64'd1);
    chk("pin_t3_va1",  64'(bus.icache_vaddr_o), 64'h400);
    tick();

    // Compressed resume and ITLB fill on thread 0
    drv(1, 0, 3, 'h1002, 0, 0, 0, 0);
    chk("pin_t4_poison", 64'(bus.poison_o), 64'd1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pin_t4_run", 64'(bus.state_o[1:0]),  64'd2);
    chk("pin_t4_va",  64'(bus.icache_vaddr_o), 64'h1000);
    tick();
    drv(1, 0, 4, 'h2000, 0, 0, 0, 0);
    chk("pin_t4_itlb", 64'(bus.itlb_fill_v_o), 64'd1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pin_t4_resume", 64'(bus.state_o[1:0]), 64'd3);
    tick();

    // Exception on thread 0 while the I$ accepts
    drv(0, 0, 0, 0, 1, 1, 0, 0);
    chk("pin_t5_poison", 64'(bus.poison_o),       64'd1);
    chk("pin_t5_tid",    64'(bus.icache_tid_o),   64'd1);
    chk("pin_t5_va",     64'(bus.icache_vaddr_o), 64'h404);
    tick();
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, 0, 0, 1, 0, 0, 0);
      chk("pin_t5_wait", 64'(bus.state_o[1:0]),  64'd1);
      chk("pin_t5_tid1", 64'(bus.icache_tid_o),   64'd1);
      chk("pin_t5_va1",  64'(bus.icache_vaddr_o), 64'(39'h408 + 39'(4 * i)));
      tick();
    end

    // Attaboy held off by the predictor for three cycles
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 9, 0, 0, 0, 0, 0);
      chk("pin_t6_atta",  64'(bus.attaboy_v_o),   64'd1);
      chk("pin_t6_nyumi", 64'(bus.fe_cmd_yumi_o), 64'd0);
      chk("pin_t6_state", 64'(bus.state_o),       64'h9);
      tick();
    end
    drv(1, 1, 9, 0, 0, 0, 0, 1);
    chk("pin_t6_yumi", 64'(bus.fe_cmd_yumi_o), 64'd1);
    tick();

    // Fences, reserved opcode, wait, command-vs-exception, compressed ITLB resume
    drv(1, 1, 6, 'h500, 0, 0, 0, 0);
    chk("pin_icfence", 64'(bus.icache_fence_o), 64'd1);
    tick();
    drv(1, 1, 7, 'h600, 0, 0, 0, 0);
    chk("pin_itlbfence", 64'(bus.itlb_fence_v_o), 64'd1);
    tick();
    drv(1, 0, 12, 'h700, 0, 0, 0, 0);
    chk("pin_rsv_yumi",   64'(bus.fe_cmd_yumi_o), 64'd1);
    chk("pin_rsv_poison", 64'(bus.poison_o),      64'd0);
    tick();
    drv(1, 1, 8, 'h800, 0, 0, 0, 0);  tick();
    drv(1, 0, 1, 'h900, 0, 1, 0, 0);
    chk("pin_cmdexc_poison", 64'(bus.poison_o), 64'd1);
    tick();
    drv(1, 1, 5, 'hA02, 0, 0, 0, 0);
    chk("pin_t0_run", 64'(bus.state_o[1:0]),  64'd2);
    chk("pin_t0_va",  64'(bus.icache_vaddr_o), 64'h900);
    tick();
    drv(0, 0, 0, 0, 1, 0, 0, 0);  tick();
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    chk("pin_t1_cva", 64'(bus.icache_vaddr_o), 64'hA00);
    tick();

    // Reset in the middle of traffic
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("pin_mid_rst_state", 64'(bus.state_o),    64'd0);
    chk("pin_mid_rst_icv",   64'(bus.icache_v_o), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("pin_post_rst_icv", 64'(bus.icache_v_o), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bp_fe_controller_mt.md
Name: bp_fe_controller_mt

Overview:
Multi-threaded successor to the single-thread FE fetch controller. It keeps a per-thread fetch FSM and a per-thread fetch PC for threads_p hardware threads. It decodes FE commands tagged with a thread ID and round-robin arbitrates the I$ fetch port among eligible threads. It sits between the BE command channel and the FE pc_gen/I$ pipeline, replacing the single-thread controller when threads_p > 1.

Parameters:
threads_p, 2, number of hardware threads (≥1; tid width = max(1, clog2(threads_p)))
vaddr_width_p, 39, virtual address width
fetch_bytes_p, 4, PC increment per accepted fetch
compressed_support_p, 1, enables resume variants (redirect PC = npc-2)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset
init_done_i  in  1  pc_gen/I$ init complete
fe_cmd_v_i  in  1  command valid
fe_cmd_tid_i  in  tid_w  target thread
fe_cmd_opcode_i  in  4  0 state_reset, 1 pc_redirect, 2 icache_fill_restart, 3 icache_fill_resume, 4 itlb_fill_restart, 5 itlb_fill_resume, 6 icache_fence, 7 itlb_fence, 8 wait, 9 attaboy
fe_cmd_npc_i  in  vaddr_width_p  command target PC
fe_cmd_yumi_o  out  1  command consumed
attaboy_v_o  out  1  attaboy forwarded to predictor
attaboy_yumi_i  in  1  predictor consumed attaboy
icache_v_o  out  1  fetch request valid
icache_tid_o  out  tid_w  granted thread
icache_vaddr_o  out  vaddr_width_p  fetch PC of granted thread
icache_fence_o  out  1  invalidate request (fence command)
icache_yumi_i  in  1  I$ accepted request
if2_exception_v_i  in  1  IF2 exception/miss
if2_exception_tid_i  in  tid_w  thread of exception
poison_o  out  threads_p  kill in-flight IF1/IF2/ISD entries of marked threads
itlb_fill_v_o  out  1  ITLB write strobe
itlb_fence_v_o  out  1  ITLB fence strobe
state_o  out  2*threads_p  per-thread state, thread t in bits [2t+1:2t]

Behaviour:
- Reset is asynchronous and active-high. While reset_i is high: all threads = RESET (enc 0), all PCs = 0, rr_ptr = 0. All outputs are 0 except icache_vaddr_o, which is don't-care.
- States, per thread: RESET(0), WAIT(1), RUN(2), RESUME(3).
- Command classes:
  - immediate = {1,2,3,6,8}
  - complex = {4,5,7}
  - attaboy = {9}
  - Opcodes 10–15 are reserved. They are yumi'd and have no other effect.
- Command acceptance:
  - Attaboy: attaboy_v_o = fe_cmd_v_i & opcode==9; fe_cmd_yumi_o = attaboy_yumi_i.
  - Thread in RESET:
    - state_reset & init_done_i: yumi; thread → RESUME; pc = npc.
    - state_reset & ~init_done_i: stall; no yumi.
    - Any other opcode: yumi and dropped.
  - Thread in WAIT/RUN/RESUME: every non-attaboy command is yumi'd the same cycle.
- Next state for an accepted non-attaboy command on a non-RESET thread:
  - wait, icache_fence → WAIT.
  - redirect, icache_fill_* → RUN.
  - itlb_fill_*, itlb_fence, state_reset → RESUME.
  - PC update: pc[tid] = npc, or npc-2 for opcodes 3/5 when compressed_support_p. If compressed_support_p=0, opcodes 3/5 behave as 2/4.
  - poison_o[tid] = 1.
  - itlb_fill_v_o = opcode∈{4,5}; itlb_fence_v_o = opcode==7; icache_fence_o = opcode==6. These strobes are combinational, same cycle as yumi.
- Fetch arbitration:
  - eligible[t] = state∈{RUN, RESUME} & ~(cmd this cycle targets t with a non-attaboy opcode).
  - Grant = first eligible thread at or after rr_ptr+1 (mod threads_p).
  - icache_v_o = |eligible; icache_tid_o/icache_vaddr_o reflect the grant combinationally.
  - On icache_yumi_i:
    - pc[grant] += fetch_bytes_p, wrapping mod 2^vaddr_width_p.
    - RESUME → RUN.
    - rr_ptr = grant.
  - Without yumi, rr_ptr holds and the request stays stable unless a command/exception changes eligibility.
- IF2 exception: thread if2_exception_tid_i → WAIT; poison_o[tid] = 1; PC unchanged.
- Simultaneous events on the same thread:
  - Accepted command beats exception: command state/PC win, poison still asserted.
  - Exception beats fetch yumi: WAIT, no increment. This requires the grant to remain exception-excluded; the exception thread is removed from eligible in that cycle.
- Different threads: command, exception and fetch updates apply independently in the same cycle.
- threads_p=1: rr logic degenerates; tid ports are 1 bit and tied/ignored.
- Reset mid-operation: immediate return to reset values. In-flight I$ responses are owned by the downstream pipeline, which is poisoned by reset.

Test Plan:
1. Reset, init_done_i=0, state_reset tid0 npc=0x8000_0000 → no yumi. Raise init_done_i → yumi; state_o[1:0]=3; icache_v_o=1, tid 0, vaddr 0x8000_0000. Yumi → RUN, next vaddr 0x8000_0004.
2. threads_p=2, both RUN at pc 0x100/0x200, icache_yumi_i every cycle → grants alternate 1,0,1,0. Vaddrs 0x200, 0x100, 0x204, 0x104.
3. Thread 1 RUN, pc_redirect tid1 npc=0x400 while granted → yumi; poison_o=2'b10. Thread 0 granted this cycle; next thread 1 fetch at 0x400.
4. icache_fill_resume tid0 npc=0x1002 (compressed) → RUN, pc=0x1000. itlb_fill_restart tid0 → itlb_fill_v_o=1, RESUME.
5. IF2 exception tid0 coinciding with icache_yumi_i for tid0 → WAIT, pc unchanged, poison_o[0]=1. Fetch continues for tid1 only.
6. Attaboy tid1 with attaboy_yumi_i=0 for 3 cycles → attaboy_v_o=1 held, no yumi, no state change. Yumi on cycle 4.
